// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths and opcode encoding for the CPU fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int IR_W   = 16;

    typedef enum logic [2:0] {
        HLT  = 3'd0,
        SKZ  = 3'd1,
        ADD  = 3'd2,
        ANDD = 3'd3,
        XORR = 3'd4,
        LDA  = 3'd5,
        STO  = 3'd6,
        JMP  = 3'd7
    } opcode_t;

endpackage
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
// Module   : pc_counter
// Brief    : 13-bit program counter with load priority over increment.
//            FETCH_PC_WRAP_EN adds a sticky wrap flag (0x1FFF -> 0x0000).
// Revision : 1.0 - initial release
// ============================================================================
module pc_counter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc,
    output logic              wrap
);

    // Program counter: reset, then load beats increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef FETCH_PC_WRAP_EN
    // Sticky flag: set when an increment (not a load) rolls over the top address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else if (inc && !load && (pc == {ADDR_W{1'b1}})) begin
            wrap <= 1'b1;
        end
    end
`else
    assign wrap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Assembles 16-bit instructions from two byte reads (high byte
//            first), holds the PC and muxes the memory address.
//            Optional feature macro: FETCH_PC_WRAP_EN (adds pc_wrap output).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              rd,
    input  logic              load_ir,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              add_sel,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              ir_valid
`ifdef FETCH_PC_WRAP_EN
    ,
    output logic              pc_wrap
`endif
);

    logic [IR_W-1:0]   ir;
    logic              bp;      // 0: expecting high byte, 1: expecting low byte
    logic [ADDR_W-1:0] pc;

    // Byte assembly: high byte then low byte; leaving load_ir low restarts at the
    // high byte, a read stall (rd=0) freezes the pointer and the register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir       <= '0;
            bp       <= 1'b0;
            ir_valid <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            if (!load_ir) begin
                bp <= 1'b0;
            end else if (rd) begin
                if (!bp) begin
                    ir[IR_W-1 -: DATA_W] <= data;
                    bp                   <= 1'b1;
                end else begin
                    ir[DATA_W-1:0] <= data;
                    bp             <= 1'b0;
                    ir_valid       <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_PC_WRAP_EN
    pc_counter u_pc_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc_pc),
        .load     (load_pc),
        .load_val (ir_addr),
        .pc       (pc),
        .wrap     (pc_wrap)
    );
`else
    logic wrap_unused;

    pc_counter u_pc_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc_pc),
        .load     (load_pc),
        .load_val (ir_addr),
        .pc       (pc),
        .wrap     (wrap_unused)
    );
`endif

    assign opcode  = ir[IR_W-1 -: 3];
    assign ir_addr = ir[ADDR_W-1:0];
    assign pc_addr = pc;
    assign addr    = add_sel ? pc : ir_addr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Scoreboard bench for fetch_unit. Stimulus pushes expected values
//            tagged with the cycle they must appear in; a monitor compares.
//            Honours FETCH_PC_WRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data;
    logic        rd;
    logic        load_ir;
    logic        inc_pc;
    logic        load_pc;
    logic        add_sel;
    logic [2:0]  opcode;
    logic [12:0] ir_addr;
    logic [12:0] pc_addr;
    logic [12:0] addr;
    logic        ir_valid;
`ifdef FETCH_PC_WRAP_EN
    logic        pc_wrap;
`endif

    fetch_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .rd       (rd),
        .load_ir  (load_ir),
        .inc_pc   (inc_pc),
        .load_pc  (load_pc),
        .add_sel  (add_sel),
        .opcode   (opcode),
        .ir_addr  (ir_addr),
        .pc_addr  (pc_addr),
        .addr     (addr),
        .ir_valid (ir_valid)
`ifdef FETCH_PC_WRAP_EN
        ,
        .pc_wrap  (pc_wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Which observable an expectation refers to
    localparam int S_PC   = 0;
    localparam int S_IR   = 1;
    localparam int S_ADDR = 2;
    localparam int S_OP   = 3;
    localparam int S_VLD  = 4;
    localparam int S_WRAP = 5;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t inst_q[$];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    // ---- stimulus helpers -------------------------------------------------
    task automatic expect_val(input int sel, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.sel = sel; e.val = v; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic expect_inst(input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.sel = S_IR; e.val = v; e.name = nm;
        inst_q.push_back(e);
    endtask

    task automatic step(input logic [7:0] d, input logic r, input logic lir,
                        input logic ipc, input logic lpc, input logic asel,
                        input logic rn);
        data = d; rd = r; load_ir = lir; inc_pc = ipc; load_pc = lpc;
        add_sel = asel; rst_n = rn;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [7:0] d);
        step(d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // ---- monitor ----------------------------------------------------------
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                logic [15:0] act;
                e = exp_q.pop_front();
                case (e.sel)
                    S_PC:   act = {3'b000, pc_addr};
                    S_IR:   act = {opcode, ir_addr};
                    S_ADDR: act = {3'b000, addr};
                    S_OP:   act = {13'd0, opcode};
`ifdef FETCH_PC_WRAP_EN
                    S_WRAP: act = {15'd0, pc_wrap};
`endif
                    default: act = {15'd0, ir_valid};
                endcase
                checks = checks + 1;
                if (e.cyc != cyc || act !== e.val) begin
                    failures = failures + 1;
                    $display("FAIL %s cycle=%0d actual=0x%04h expected=0x%04h (due cycle %0d)",
                             e.name, cyc, act, e.val, e.cyc);
                end
            end
            if (ir_valid === 1'b1) begin
                checks = checks + 1;
                if (inst_q.size() == 0 || inst_q[0].cyc != cyc) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_ir_valid cycle=%0d actual=1 expected=0", cyc);
                end else begin
                    exp_t e;
                    e = inst_q.pop_front();
                    if ({opcode, ir_addr} !== e.val) begin
                        failures = failures + 1;
                        $display("FAIL %s cycle=%0d actual_ir=0x%04h expected_ir=0x%04h",
                                 e.name, cyc, {opcode, ir_addr}, e.val);
                    end
                end
            end else if (inst_q.size() > 0 && inst_q[0].cyc <= cyc) begin
                exp_t e;
                e = inst_q.pop_front();
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL %s_pulse cycle=%0d actual_ir_valid=%b expected=1",
                         e.name, cyc, ir_valid);
            end
        end
    end

    // ---- watchdog ---------------------------------------------------------
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog actual=timeout expected=finish");
            $fatal(1, "watchdog expired");
        end
    end

    // ---- directed stimulus -------------------------------------------------
    initial begin
        data = 8'h00; rd = 1'b0; load_ir = 1'b0; inc_pc = 1'b0;
        load_pc = 1'b0; add_sel = 1'b1; rst_n = 1'b0;

        // Reset state
        expect_val(S_PC,  16'h0000, "reset_pc");
        expect_val(S_IR,  16'h0000, "reset_ir");
        expect_val(S_VLD, 16'h0000, "reset_ir_valid");
`ifdef FETCH_PC_WRAP_EN
        expect_val(S_WRAP, 16'h0000, "reset_pc_wrap");
`endif
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // LDA 0x0123 assembly
        expect_val(S_OP, 16'h0005, "lda_opcode_after_high");
        expect_val(S_IR, 16'hA100, "lda_ir_after_high");
        fetch(8'hA1);
        expect_val(S_IR, 16'hA123, "lda_ir");
        expect_inst(16'hA123, "lda_inst");
        fetch(8'h23);
        idle();

        // Stall on rd=0 between bytes
        expect_val(S_IR, 16'h4023, "stall_high");
        fetch(8'h40);
        expect_val(S_IR, 16'h4023, "stall_hold");
        step(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_inst(16'h4010, "stall_inst");
        fetch(8'h10);
        idle();

        // Abandoned fetch restarts at the high byte
        expect_val(S_IR, 16'hE010, "abandon_high");
        fetch(8'hE0);
        expect_val(S_IR, 16'hE010, "abandon_keep_ir");
        step(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_val(S_IR, 16'h4010, "abandon_restart_high");
        expect_val(S_OP, 16'h0002, "abandon_opcode_add");
        fetch(8'h40);
        expect_inst(16'h4010, "abandon_inst");
        fetch(8'h10);

        // Increment, then jump with load_pc and inc_pc together
        expect_val(S_PC, 16'h0001, "inc_pc");
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        fetch(8'hE0);
        expect_inst(16'hE055, "jmp_inst");
        fetch(8'h55);
        expect_val(S_PC,   16'h0055, "jump_priority_pc");
        expect_val(S_ADDR, 16'h0055, "jump_addr_pc");
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // PC load uses the IR from before the edge while IR captures a new byte
        expect_val(S_PC, 16'h0056, "inc_after_jump");
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_val(S_PC, 16'h0055, "load_old_ir_pc");
        expect_val(S_IR, 16'h1255, "load_parallel_ir");
        step(8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_inst(16'h1234, "parallel_inst");
        fetch(8'h34);

        // Wrap 0x1FFF -> 0x0000
        fetch(8'hFF);
        expect_inst(16'hFFFF, "ffff_inst");
        fetch(8'hFF);
        expect_val(S_PC, 16'h1FFF, "pc_at_top");
`ifdef FETCH_PC_WRAP_EN
        expect_val(S_WRAP, 16'h0000, "wrap_before");
`endif
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_val(S_PC, 16'h0000, "pc_wrap_to_zero");
`ifdef FETCH_PC_WRAP_EN
        expect_val(S_WRAP, 16'h0001, "wrap_set");
`endif
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_val(S_PC, 16'h0001, "pc_after_wrap");
`ifdef FETCH_PC_WRAP_EN
        expect_val(S_WRAP, 16'h0001, "wrap_sticky");
`endif
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Address mux: pc=0x0010, ir_addr=0x0AAA
        fetch(8'h00);
        expect_inst(16'h0010, "ir_0010_inst");
        fetch(8'h10);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        fetch(8'h0A);
        expect_inst(16'h0AAA, "ir_0aaa_inst");
        fetch(8'hAA);
        expect_val(S_PC,   16'h0010, "mux_pc");
        expect_val(S_ADDR, 16'h0010, "mux_addr_pc");
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_val(S_ADDR, 16'h0AAA, "mux_addr_ir");
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during a fetch (and with inc/load requests) wins
        expect_val(S_IR, 16'hC3AA, "midfetch_high");
        fetch(8'hC3);
        expect_val(S_PC,  16'h0000, "midreset_pc");
        expect_val(S_IR,  16'h0000, "midreset_ir");
        expect_val(S_VLD, 16'h0000, "midreset_ir_valid");
`ifdef FETCH_PC_WRAP_EN
        expect_val(S_WRAP, 16'h0000, "midreset_wrap");
`endif
        step(8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_val(S_IR, 16'h5B00, "post_reset_high");
        fetch(8'h5B);
        expect_inst(16'h5B01, "post_reset_inst");
        fetch(8'h01);
        idle();
        idle();
        idle();

        checks = checks + 1;
        if (exp_q.size() != 0 || inst_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_drain actual=%0d/%0d pending expected=0/0",
                     exp_q.size(), inst_q.size());
        end

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
